load_extender: RTL
==================

# load_extender

Multi-beat load-data assembler and extender for the memory read path. It collects an 8/16/32/64-bit load item from a narrow memory bus one beat at a time, then zero- or sign-extends it to the register width. The result is presented to the writeback stage with a valid/ready handshake. It is the sequential, bus-width- and size-generic successor to the combinational sign extender, and sits between the bus interface and the register file write port.

## Interface

- BUS_WIDTH, 8, memory bus beat width; legal values 8, 16, 32, 64; must be ≤ DATA_WIDTH.
- DATA_WIDTH, 32, extended output width; legal values 32 or 64.
- clk  input  1  sole clock; all state updates on the rising edge.
- resetN  input  1  asynchronous, active-low reset.
- startValid  input  1  a load request is presented.
- startReady  output  1  request accepted this cycle when high with startValid; equals (state == IDLE).
- size  input  2  item size, sampled at start: 00 = byte, 01 = half, 10 = word, 11 = doubleword.
- signExtend  input  1  sampled at start: 1 replicates item MSB, 0 fills with zeros.
- busData  input  BUS_WIDTH  read beat; least-significant beat first.
- busValid  input  1  busData is valid this cycle.
- busReady  output  1  beat consumed when high with busValid; equals (state == COLLECT).
- out  output  DATA_WIDTH  extended result, registered.
- outValid  output  1  out holds a result.
- outReady  input  1  consumer takes the result.
- sizeError  output  1  registered; qualifies out while outValid is high.

## Operation

- ITEM_W = 8 << size. If ITEM_W > DATA_WIDTH, set sizeError, clamp ITEM_W to DATA_WIDTH and use zero fill (no extension).
- Beats required: N = max(1, ITEM_W / BUS_WIDTH). The beat counter is sized for DATA_WIDTH/BUS_WIDTH.
- State machine:
  - IDLE: start handshake → capture size, signExtend and N; clear the assembly register and counter; go to COLLECT.
  - COLLECT: each busValid beat is written into assembly bits [k·BUS_WIDTH +: BUS_WIDTH], where k is the beat index. Cycles without busValid hold all state. After the Nth beat, go to DONE.
  - DONE: outValid is high. When outReady is high, go to IDLE.
- Partial beats: if BUS_WIDTH > ITEM_W, only busData[ITEM_W-1:0] is used and the upper beat bits are ignored.
- Extension: out[ITEM_W-1:0] = item. out[DATA_WIDTH-1:ITEM_W] = signExtend ? item[ITEM_W-1] : 0. When ITEM_W = DATA_WIDTH, no bits are filled.
- out and sizeError are loaded on the cycle the last beat is accepted. They stay stable through all of DONE.
- startValid outside IDLE is ignored (no queuing). busValid outside COLLECT is ignored.

## Timing

- Reset (asynchronous assert, synchronous-edge deassert): state = IDLE; out = 0; outValid = 0; sizeError = 0; counter = 0; busReady = 0; startReady = 1.
- Start accepted in cycle t → busReady goes high in t+1.
- Last beat accepted in cycle u → outValid = 1 and out valid in u+1.
- Minimum latency from start to outValid: N+1 cycles, with busValid continuously high.
- Result taken in cycle v (outValid && outReady) → outValid = 0 and startReady = 1 in v+1. A new start can be accepted in v+1.
- There is no same-cycle result-to-start bypass. Transaction throughput is at most one per N+2 cycles.
- Reset asserted mid-COLLECT or in DONE: the transaction is discarded immediately and no outValid is produced.
- outValid never drops without outReady. out never changes while outValid is high.

## Test plan

- BUS_WIDTH=8, DATA_WIDTH=32, byte load of 0x80:
  - signExtend=1 → out=0xFFFFFF80, outValid two cycles after start.
  - signExtend=0 → out=0x00000080.
- Half load, beats 0x34 then 0x82, signExtend=1 → out=0xFFFF8234, sizeError=0. Repeat with signExtend=0 → 0x00008234.
- Word load, beats 0x78,0x56,0x34,0x12 with busValid low for 2 cycles between beats 2 and 3 → out=0x12345678. Latency grows by exactly 2 cycles.
- Hold outReady low for 3 cycles in DONE while pulsing startValid and busValid → out, outValid and sizeError are stable, startReady=0, and no beat is consumed. Raising outReady returns the block to IDLE the next cycle.
- Drop resetN after the second beat of a word load → outValid=0, out=0, startReady=1 asynchronously. A following byte load of 0x7F with signExtend=1 gives 0x0000007F.
- size=11 with DATA_WIDTH=32 and beats 0xEF,0xBE,0xAD,0xDE → 4 beats collected, out=0xDEADBEEF, sizeError=1. With DATA_WIDTH=64 and BUS_WIDTH=16, beats 0x0001,0x0002,0x0003,0x8004 → out=0x8004000300020001, sizeError=0.

Source files
------------

// File: rtl/load_extender.sv
// Multi-beat load assembler: collects an 8/16/32/64-bit item LSB beat first, then zero/sign-extends it.
// Latency N+1 cycles start-to-outValid with back-to-back beats; result held until outReady, no start/beat accepted meanwhile.
module load_extender #(
    parameter int BUS_WIDTH  = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startValid,
    output logic                  startReady,
    input  logic [1:0]            size,
    input  logic                  signExtend,
    input  logic [BUS_WIDTH-1:0]  busData,
    input  logic                  busValid,
    output logic                  busReady,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  outValid,
    input  logic                  outReady,
    output logic                  sizeError
);
    localparam int NB = DATA_WIDTH / BUS_WIDTH;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         last_q, last_d;
    logic [6:0]            item_w_q, item_w_d;
    logic                  sign_q, sign_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  size_err_q, size_err_d;

    logic [DATA_WIDTH-1:0] item_mask, item_msb, item, ext;
    int                    req_w, req_n;

    // Mask of the live item bits and a one-hot marker of its MSB.
    always_comb begin
        for (int b = 0; b < DATA_WIDTH; b++) begin
            item_mask[b] = (b < int'(item_w_q));
        end
        item_msb = item_mask & ~(item_mask >> 1);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        item_w_d   = item_w_q;
        sign_d     = sign_q;
        err_d      = err_q;
        asm_d      = asm_q;
        out_d      = out_q;
        size_err_d = size_err_q;
        req_w      = 8 << size;
        req_n      = 1;
        item       = '0;
        ext        = '0;

        unique case (state_q)
            IDLE: begin
                if (startValid) begin
                    // Oversized items are clamped and always zero-filled.
                    err_d  = (req_w > DATA_WIDTH);
                    sign_d = signExtend && !(req_w > DATA_WIDTH);
                    if (req_w > DATA_WIDTH) begin
                        req_w = DATA_WIDTH;
                    end
                    req_n = req_w / BUS_WIDTH;
                    if (req_n < 1) begin
                        req_n = 1;
                    end
                    item_w_d = 7'(req_w);
                    last_d   = CW'(req_n - 1);
                    cnt_d    = '0;
                    asm_d    = '0;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (busValid) begin
                    for (int i = 0; i < NB; i++) begin
                        if (cnt_q == CW'(i)) begin
                            asm_d[i*BUS_WIDTH +: BUS_WIDTH] = busData;
                        end
                    end
                    if (cnt_q == last_q) begin
                        // Masking also drops the unused upper bits of a partial beat.
                        item       = asm_d & item_mask;
                        ext        = item | ((sign_q && |(item & item_msb)) ? ~item_mask : '0);
                        out_d      = ext;
                        size_err_d = err_q;
                        state_d    = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (outReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= '0;
            item_w_q   <= '0;
            sign_q     <= 1'b0;
            err_q      <= 1'b0;
            asm_q      <= '0;
            out_q      <= '0;
            size_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            item_w_q   <= item_w_d;
            sign_q     <= sign_d;
            err_q      <= err_d;
            asm_q      <= asm_d;
            out_q      <= out_d;
            size_err_q <= size_err_d;
        end
    end

    assign startReady = (state_q == IDLE);
    assign busReady   = (state_q == COLLECT);
    assign outValid   = (state_q == DONE);
    assign out        = out_q;
    assign sizeError  = size_err_q;
endmodule
